// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-port ALU arbiter: datapath width,
// ALU function codes and the sequencer state encoding.
package alu_arbiter_pkg;

  localparam int NUM_BITS = 16;

  localparam logic [3:0] FN_ADD  = 4'h0;
  localparam logic [3:0] FN_SUB  = 4'h1;
  localparam logic [3:0] FN_ID   = 4'h2;
  localparam logic [3:0] FN_NOT  = 4'h3;
  localparam logic [3:0] FN_AND  = 4'h4;
  localparam logic [3:0] FN_OR   = 4'h5;
  localparam logic [3:0] FN_NAND = 4'h6;
  localparam logic [3:0] FN_NOR  = 4'h7;
  localparam logic [3:0] FN_XOR  = 4'h8;
  localparam logic [3:0] FN_XNOR = 4'h9;
  localparam logic [3:0] FN_LLS  = 4'hA;
  localparam logic [3:0] FN_LRS  = 4'hB;
  localparam logic [3:0] FN_ALS  = 4'hC;
  localparam logic [3:0] FN_ARS  = 4'hD;
  localparam logic [3:0] FN_TCP  = 4'hE;
  localparam logic [3:0] FN_ZERO = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU. Shifts move by one bit; overflow is only
// meaningful for ADD and SUB and reads 0 for every other function.
module alu_arbiter_alu #(
  parameter int NUM_BITS = 16
) (
  input  logic [NUM_BITS-1:0] a_i,
  input  logic [NUM_BITS-1:0] b_i,
  input  logic [3:0]          func_i,
  output logic [NUM_BITS-1:0] c_o,
  output logic                overflow_o
);
  import alu_arbiter_pkg::*;

  localparam int MSB = NUM_BITS - 1;

  logic [NUM_BITS-1:0] sum;
  logic [NUM_BITS-1:0] diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  // Function decode; signed overflow is judged from operand and result sign bits
  always_comb begin
    c_o        = '0;
    overflow_o = 1'b0;
    case (func_i)
      FN_ADD: begin
        c_o        = sum;
        overflow_o = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
      end
      FN_SUB: begin
        c_o        = diff;
        overflow_o = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
      end
      FN_ID:   c_o = a_i;
      FN_NOT:  c_o = ~a_i;
      FN_AND:  c_o = a_i & b_i;
      FN_OR:   c_o = a_i | b_i;
      FN_NAND: c_o = ~(a_i & b_i);
      FN_NOR:  c_o = ~(a_i | b_i);
      FN_XOR:  c_o = a_i ^ b_i;
      FN_XNOR: c_o = ~(a_i ^ b_i);
      FN_LLS, FN_ALS: c_o = {a_i[MSB-1:0], 1'b0};
      FN_LRS:  c_o = {1'b0, a_i[MSB:1]};
      FN_ARS:  c_o = {a_i[MSB], a_i[MSB:1]};
      FN_TCP:  c_o = -a_i;
      default: c_o = '0;  // FN_ZERO
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that serialises two requesters through one ALU.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a request; winner's ready driven combinationally
//   EXEC    | latched operands drive the ALU; result captured at the edge
//   RESP    | result held on the owner's response port until it is taken
module alu_arbiter #(
  parameter int NUM_BITS = alu_arbiter_pkg::NUM_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [NUM_BITS-1:0] req0_a,
  input  logic [NUM_BITS-1:0] req0_b,
  input  logic [3:0]          req0_func,
  output logic                resp0_valid,
  input  logic                resp0_ready,
  output logic [NUM_BITS-1:0] resp0_c,
  output logic                resp0_overflow,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [NUM_BITS-1:0] req1_a,
  input  logic [NUM_BITS-1:0] req1_b,
  input  logic [3:0]          req1_func,
  output logic                resp1_valid,
  input  logic                resp1_ready,
  output logic [NUM_BITS-1:0] resp1_c,
  output logic                resp1_overflow
);
  import alu_arbiter_pkg::*;

  arb_state_e          state_q;
  logic                owner_q;
  logic                last_grant_q;
  logic [NUM_BITS-1:0] a_q;
  logic [NUM_BITS-1:0] b_q;
  logic [3:0]          func_q;
  logic [NUM_BITS-1:0] c_q;
  logic                ovf_q;
  logic                resp0_valid_q;
  logic                resp1_valid_q;

  logic                any_req_d;
  logic                grant1_d;
  logic [NUM_BITS-1:0] alu_c;
  logic                alu_ovf;

  // Winner pick: a lone requester wins, a tie goes to whoever was not served last
  always_comb begin
    any_req_d = req0_valid | req1_valid;
    grant1_d  = req1_valid & (~req0_valid | ~last_grant_q);
  end

  assign req0_ready = (state_q == ST_IDLE) & req0_valid & ~grant1_d;
  assign req1_ready = (state_q == ST_IDLE) & grant1_d;

  alu_arbiter_alu #(.NUM_BITS(NUM_BITS)) u_alu (
    .a_i        (a_q),
    .b_i        (b_q),
    .func_i     (func_q),
    .c_o        (alu_c),
    .overflow_o (alu_ovf)
  );

  // Sequencer: accept in IDLE, capture the ALU in EXEC, hold the response in RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      a_q           <= '0;
      b_q           <= '0;
      func_q        <= FN_ZERO;
      c_q           <= '0;
      ovf_q         <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req_d) begin
            owner_q <= grant1_d;
            a_q     <= grant1_d ? req1_a : req0_a;
            b_q     <= grant1_d ? req1_b : req0_b;
            func_q  <= grant1_d ? req1_func : req0_func;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          c_q           <= alu_c;
          ovf_q         <= alu_ovf;
          last_grant_q  <= owner_q;
          resp0_valid_q <= ~owner_q;
          resp1_valid_q <= owner_q;
          state_q       <= ST_RESP;
        end
        ST_RESP: begin
          if (owner_q ? resp1_ready : resp0_ready) begin
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp0_valid    = resp0_valid_q;
  assign resp1_valid    = resp1_valid_q;
  assign resp0_c        = c_q;
  assign resp1_c        = c_q;
  assign resp0_overflow = ovf_q;
  assign resp1_overflow = ovf_q;

endmodule
